// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams {index, value} beats of the register file.
// Define REGDUMP_CSUM_EN to append a trailing XOR checksum beat.
module regfile_dump_reader #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_idx,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          out_csum,
   output logic          busy,
   output logic          stall_req,
   output logic          done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SEND,
      CSUM,
      FIN
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

`ifdef REGDUMP_CSUM_EN
   localparam logic REG_LAST_ENDS = 1'b0;
   logic [DW-1:0] acc;
   logic          csum_q;
   assign out_csum = csum_q;
`else
   localparam logic REG_LAST_ENDS = 1'b1;
   assign out_csum = 1'b0;
`endif

   state_t        state;
   logic [AW-1:0] idx;
   logic          primed;

   assign rd_addr   = idx;
   assign stall_req = busy;

   // The first fetch of a scan waits one cycle so the
   // freshly cleared address settles through the read port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         idx       <= '0;
         primed    <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef REGDUMP_CSUM_EN
         acc       <= '0;
         csum_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  idx    <= '0;
                  primed <= 1'b0;
                  busy   <= 1'b1;
`ifdef REGDUMP_CSUM_EN
                  acc    <= '0;
`endif
                  state  <= FETCH;
               end
            end
            FETCH: begin
               if (!primed) begin
                  primed <= 1'b1;
               end else begin
                  out_data  <= rd_data;
                  out_idx   <= idx;
                  out_valid <= 1'b1;
                  out_last  <= (idx == LAST) && REG_LAST_ENDS;
`ifdef REGDUMP_CSUM_EN
                  csum_q    <= 1'b0;
                  acc       <= acc ^ rd_data;
`endif
                  state     <= SEND;
               end
            end
            SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (idx != LAST) begin
                     idx   <= idx + AW'(1);
                     state <= FETCH;
                  end else begin
`ifdef REGDUMP_CSUM_EN
                     state <= CSUM;
`else
                     state <= FIN;
`endif
                  end
               end
            end
`ifdef REGDUMP_CSUM_EN
            CSUM: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_idx   <= '0;
                  out_data  <= acc;
                  out_last  <= 1'b1;
                  csum_q    <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= FIN;
               end
            end
`endif
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed + randomized scans of regfile_dump_reader
// against a beat-list model built from the register file contents.
module tb_regfile_dump_reader;

   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          out_valid;
   logic [AW-1:0] out_idx;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_csum;
   logic          busy;
   logic          stall_req;
   logic          done;

   logic [DW-1:0] rf [NREGS];
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] last_data;

   typedef struct {
      int          idx;
      logic [31:0] data;
      bit          last;
      bit          csum;
   } beat_t;
   beat_t expq[$];

   always #5 clk = ~clk;
   assign rd_data = rf[rd_addr];

   regfile_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_data(out_data),
      .out_last(out_last), .out_csum(out_csum),
      .busy(busy), .stall_req(stall_req), .done(done)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected beat list: every register in order, optionally a checksum.
   task automatic build_model();
      logic [31:0] x;
      x = '0;
      expq.delete();
      for (int i = 0; i < NREGS; i++) begin
         beat_t b;
         b.idx  = i;
         b.data = rf[i];
         b.csum = 1'b0;
`ifdef REGDUMP_CSUM_EN
         b.last = 1'b0;
`else
         b.last = (i == NREGS - 1);
`endif
         x ^= rf[i];
         expq.push_back(b);
      end
`ifdef REGDUMP_CSUM_EN
      begin
         beat_t c;
         c.idx = 0; c.data = x; c.last = 1'b1; c.csum = 1'b1;
         expq.push_back(c);
      end
`endif
   endtask

   task automatic outs_zero(string tag);
      chk(tag, {rd_addr, out_valid, out_idx, out_data, out_last,
                out_csum, busy, stall_req, done}, 64'd0);
   endtask

   task automatic run_scan(int stall_at, int restart_at, int abort_at);
      int  k = 0, hold = 0, cyc = 0, last_hs = 0, post = 0, ndone = 0;
      bit  seen = 0, restarted = 0;
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_after_N", busy, 1);
      chk("stall_after_N", stall_req, 1);
      chk("valid_after_N", out_valid, 0);
      @(negedge clk);
      chk("valid_after_N1", out_valid, 0);
      @(negedge clk);
      chk("valid_after_N2", out_valid, 1);
      while (cyc < 500) begin
         start = 1'b0;
         if (done) begin
            ndone++;
            chk("done_gap", cyc - last_hs, 2);
         end
         if (out_valid && k < expq.size()) begin
            if (!seen) begin
               if (k > 0) chk("beat_gap", cyc - last_hs, 2);
               seen = 1;
            end
            if (k == abort_at) begin
               #2 reset = 1'b0;
               #1 outs_zero("async_reset_outs");
               repeat (3) begin
                  @(negedge clk);
                  chk("no_done_abort", done, 0);
               end
               reset = 1'b1;
               return;
            end
            if (k == restart_at && !restarted) begin
               start = 1'b1;
               restarted = 1;
            end
            if (k == stall_at && hold < 5) begin
               out_ready = 1'b0;
               hold++;
               chk("stall_idx", out_idx, expq[k].idx);
               chk("stall_data", out_data, expq[k].data);
            end else begin
               out_ready = 1'b1;
               chk("beat_idx", out_idx, expq[k].idx);
               chk("beat_data", out_data, expq[k].data);
               chk("beat_last", out_last, expq[k].last);
               chk("beat_csum", out_csum, expq[k].csum);
               last_data = out_data;
               last_hs = cyc;
               seen = 0;
               k++;
            end
         end
         if (k >= expq.size()) begin
            post++;
            if (post > 6) break;
         end
         @(negedge clk);
         cyc++;
      end
      chk("beat_count", k, expq.size());
      chk("done_count", ndone, 1);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      #1 reset = 1'b0;
      #1 outs_zero("reset_outs");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NREGS; i++) rf[i] = 32'h1000_0000 + i;
      build_model();
      run_scan(-1, -1, -1);
      run_scan(7, 10, -1);

      for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
      build_model();
      run_scan(-1, -1, 12);
      run_scan(-1, -1, -1);

      repeat (3) begin
         for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
         build_model();
         run_scan($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1), -1);
      end

`ifdef REGDUMP_CSUM_EN
      for (int i = 0; i < NREGS; i++) rf[i] = i;
      build_model();
      run_scan(-1, -1, -1);
      chk("csum_seq", last_data, 32'h0000_0000);
      rf[5] = 32'hDEAD_BEEF;
      build_model();
      run_scan(-1, -1, -1);
      chk("csum_deadbeef", last_data, 32'hDEAD_BEEA);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
